// File: rtl/bv_match_enum_pkg.sv
// Shared definitions for the multi-match bit-vector enumerator: default widths,
// FSM state encoding and an elaboration-time clog2 helper.
package bv_match_enum_pkg;

    localparam int WIDTH_BV_DEF    = 64;
    localparam int WIDTH_COUNT_DEF = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bv_match_enum_ffs.sv
// Combinational find-first-set: a log2-depth tree of pairwise merges; each level
// picks the preferred non-empty child and prepends one index bit.
module bv_ffs #(
    parameter int WIDTH       = 64,
    parameter int WIDTH_COUNT = 6,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic [WIDTH-1:0]       vec,
    output logic [WIDTH_COUNT-1:0] idx,
    output logic                   any
);

    for (genvar l = 0; l <= WIDTH_COUNT; l++) begin : g_lvl
        logic [(WIDTH>>l)-1:0]                  node_any;
        logic [(WIDTH>>l)-1:0][WIDTH_COUNT-1:0] node_idx;
        if (l == 0) begin : g_leaf
            assign node_any = vec;
            assign node_idx = '0;
        end else begin : g_node
            for (genvar n = 0; n < (WIDTH >> l); n++) begin : g_n
                logic take_hi;
                // Descending order prefers the upper half whenever it holds a bit.
                assign take_hi = MSB_FIRST ? g_lvl[l-1].node_any[2*n+1]
                                           : !g_lvl[l-1].node_any[2*n];
                assign node_any[n] = g_lvl[l-1].node_any[2*n] | g_lvl[l-1].node_any[2*n+1];
                assign node_idx[n] = take_hi
                    ? (g_lvl[l-1].node_idx[2*n+1] | (WIDTH_COUNT'(1) << (l-1)))
                    : g_lvl[l-1].node_idx[2*n];
            end
        end
    end

    assign any = g_lvl[WIDTH_COUNT].node_any[0];
    assign idx = g_lvl[WIDTH_COUNT].node_idx[0];

endmodule

// File: rtl/bv_match_enum.sv
// Enumerates every set bit of a rule bit vector, one index per beat, with
// selectable scan order, a per-vector beat cap and back-to-back vector reload.
module bv_match_enum
    import bv_match_enum_pkg::*;
#(
    parameter int WIDTH_BV    = WIDTH_BV_DEF,
    parameter int WIDTH_COUNT = WIDTH_COUNT_DEF,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int MAX_MATCH   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bv_in_valid,
    output logic                   bv_in_ready,
    input  logic [WIDTH_BV-1:0]    bv_in,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [WIDTH_COUNT-1:0] id,
    output logic                   id_last,
    output logic                   id_miss,
    output logic                   id_trunc
);

    if (WIDTH_COUNT != clog2(WIDTH_BV)) begin : g_bad_width
        $error("bv_match_enum: WIDTH_COUNT must equal log2(WIDTH_BV)");
    end

    localparam logic [WIDTH_COUNT:0] CAP = (WIDTH_COUNT+1)'(MAX_MATCH - 1);

    state_t                 state, state_nxt;
    logic [WIDTH_BV-1:0]    bv_reg, bv_nxt;
    logic [WIDTH_COUNT:0]   cnt, cnt_nxt;
    logic [WIDTH_COUNT-1:0] ffs_idx;
    logic                   ffs_any;
    logic [WIDTH_BV-1:0]    rest;
    logic                   scan, at_cap, xfer, done, accept;

    bv_ffs #(
        .WIDTH       (WIDTH_BV),
        .WIDTH_COUNT (WIDTH_COUNT),
        .MSB_FIRST   (MSB_FIRST)
    ) u_ffs (
        .vec (bv_reg),
        .idx (ffs_idx),
        .any (ffs_any)
    );

    assign scan   = (state == SCAN);
    assign rest   = bv_reg & ~(WIDTH_BV'(1) << ffs_idx);
    assign at_cap = (cnt == CAP);

    // Every beat output is gated by SCAN so IDLE presents all zeros.
    assign id_valid = scan;
    assign id       = (scan && ffs_any) ? ffs_idx : '0;
    assign id_miss  = scan && !ffs_any;
    assign id_last  = scan && (!ffs_any || (rest == '0) || at_cap);
    assign id_trunc = scan && ffs_any && at_cap && (rest != '0);

    assign xfer        = id_valid && id_ready;
    assign done        = xfer && id_last;
    assign bv_in_ready = !scan || done;
    assign accept      = bv_in_valid && bv_in_ready;

    always_comb begin
        state_nxt = state;
        bv_nxt    = bv_reg;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SCAN;
            bv_nxt    = bv_in;
            cnt_nxt   = '0;
        end else if (done) begin
            state_nxt = IDLE;
            bv_nxt    = '0;
            cnt_nxt   = '0;
        end else if (xfer) begin
            bv_nxt  = rest;
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            bv_reg <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            bv_reg <= bv_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bv_match_enum.sv
// Directed bench: three instances (ascending, descending, cap of 2) share one
// stimulus stream; each beat is checked as {valid, id, last, miss, trunc}.
module tb_bv_match_enum;

    logic        clk = 1'b0;
    logic        reset;
    logic        bv_in_valid;
    logic [63:0] bv_in;
    logic        id_ready;

    logic       a_bv_in_ready, a_id_valid, a_id_last, a_id_miss, a_id_trunc;
    logic [5:0] a_id;
    logic       b_bv_in_ready, b_id_valid, b_id_last, b_id_miss, b_id_trunc;
    logic [5:0] b_id;
    logic       c_bv_in_ready, c_id_valid, c_id_last, c_id_miss, c_id_trunc;
    logic [5:0] c_id;

    logic [9:0] a_beat, b_beat, c_beat;
    assign a_beat = {a_id_valid, a_id, a_id_last, a_id_miss, a_id_trunc};
    assign b_beat = {b_id_valid, b_id, b_id_last, b_id_miss, b_id_trunc};
    assign c_beat = {c_id_valid, c_id, c_id_last, c_id_miss, c_id_trunc};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bv_match_enum #(.WIDTH_BV(64), .WIDTH_COUNT(6), .MSB_FIRST(1'b0), .MAX_MATCH(64)) u_a (
        .clk(clk), .reset(reset), .bv_in_valid(bv_in_valid), .bv_in_ready(a_bv_in_ready),
        .bv_in(bv_in), .id_valid(a_id_valid), .id_ready(id_ready), .id(a_id),
        .id_last(a_id_last), .id_miss(a_id_miss), .id_trunc(a_id_trunc));

    bv_match_enum #(.WIDTH_BV(64), .WIDTH_COUNT(6), .MSB_FIRST(1'b1), .MAX_MATCH(64)) u_b (
        .clk(clk), .reset(reset), .bv_in_valid(bv_in_valid), .bv_in_ready(b_bv_in_ready),
        .bv_in(bv_in), .id_valid(b_id_valid), .id_ready(id_ready), .id(b_id),
        .id_last(b_id_last), .id_miss(b_id_miss), .id_trunc(b_id_trunc));

    bv_match_enum #(.WIDTH_BV(64), .WIDTH_COUNT(6), .MSB_FIRST(1'b0), .MAX_MATCH(2)) u_c (
        .clk(clk), .reset(reset), .bv_in_valid(bv_in_valid), .bv_in_ready(c_bv_in_ready),
        .bv_in(bv_in), .id_valid(c_id_valid), .id_ready(id_ready), .id(c_id),
        .id_last(c_id_last), .id_miss(c_id_miss), .id_trunc(c_id_trunc));

    function automatic logic [9:0] bt(input logic v, input logic [5:0] i,
                                      input logic l, input logic m, input logic t);
        return {v, i, l, m, t};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; bv_in_valid = 1'b0; bv_in = '0; id_ready = 1'b1;
        tick(); tick();
        chk("rst_ready", 64'(a_bv_in_ready), 64'd1);
        chk("rst_beat",  64'(a_beat), 64'(bt(0, 0, 0, 0, 0)));
        reset = 1'b0;
        tick();

        // Ascending on A, descending on B, capped at 2 on C.
        bv_in = 64'h0000_0000_0000_8421; bv_in_valid = 1'b1;
        tick();
        bv_in_valid = 1'b0;
        chk("t1_a0", 64'(a_beat), 64'(bt(1, 0, 0, 0, 0)));
        chk("t2_b0", 64'(b_beat), 64'(bt(1, 15, 0, 0, 0)));
        chk("t1_c0", 64'(c_beat), 64'(bt(1, 0, 0, 0, 0)));
        chk("t1_rdy_busy", 64'(a_bv_in_ready), 64'd0);
        tick();
        chk("t1_a1", 64'(a_beat), 64'(bt(1, 5, 0, 0, 0)));
        chk("t2_b1", 64'(b_beat), 64'(bt(1, 10, 0, 0, 0)));
        chk("t1_c1", 64'(c_beat), 64'(bt(1, 5, 1, 0, 1)));
        tick();
        chk("t1_a2", 64'(a_beat), 64'(bt(1, 10, 0, 0, 0)));
        chk("t2_b2", 64'(b_beat), 64'(bt(1, 5, 0, 0, 0)));
        tick();
        chk("t1_a3", 64'(a_beat), 64'(bt(1, 15, 1, 0, 0)));
        chk("t2_b3", 64'(b_beat), 64'(bt(1, 0, 1, 0, 0)));
        chk("t1_rdy_last", 64'(a_bv_in_ready), 64'd1);
        tick();
        chk("t1_idle", 64'(a_beat), 64'(bt(0, 0, 0, 0, 0)));

        // Empty vector yields a single miss beat.
        bv_in = 64'h0; bv_in_valid = 1'b1;
        tick();
        bv_in_valid = 1'b0;
        chk("t3_miss", 64'(a_beat), 64'(bt(1, 0, 1, 1, 0)));
        tick();
        chk("t3_idle", 64'(a_beat), 64'(bt(0, 0, 0, 0, 0)));
        chk("t3_ready", 64'(a_bv_in_ready), 64'd1);

        // Cap of 2 drops bits 2 and 3 on C; A and B run all four.
        bv_in = 64'hF; bv_in_valid = 1'b1;
        tick();
        bv_in_valid = 1'b0;
        chk("t4_c0", 64'(c_beat), 64'(bt(1, 0, 0, 0, 0)));
        chk("t4_b0", 64'(b_beat), 64'(bt(1, 3, 0, 0, 0)));
        tick();
        chk("t4_c1", 64'(c_beat), 64'(bt(1, 1, 1, 0, 1)));
        tick();
        chk("t4_c_idle", 64'(c_beat), 64'(bt(0, 0, 0, 0, 0)));
        chk("t4_a2", 64'(a_beat), 64'(bt(1, 2, 0, 0, 0)));
        tick();
        chk("t4_a3", 64'(a_beat), 64'(bt(1, 3, 1, 0, 0)));
        tick();

        // Stall on beat 0, a refused vector during the stall, then a back-to-back reload.
        bv_in = 64'h8000_0000_0000_0001; bv_in_valid = 1'b1;
        tick();
        bv_in_valid = 1'b0; id_ready = 1'b0;
        chk("t5_hold1", 64'(a_beat), 64'(bt(1, 0, 0, 0, 0)));
        bv_in = 64'hFF00; bv_in_valid = 1'b1;
        tick();
        chk("t5_hold2", 64'(a_beat), 64'(bt(1, 0, 0, 0, 0)));
        chk("t5_stall_rdy", 64'(a_bv_in_ready), 64'd0);
        bv_in_valid = 1'b0;
        tick();
        chk("t5_hold3", 64'(a_beat), 64'(bt(1, 0, 0, 0, 0)));
        chk("t5_b_hold", 64'(b_beat), 64'(bt(1, 63, 0, 0, 0)));
        id_ready = 1'b1;
        tick();
        chk("t5_a63", 64'(a_beat), 64'(bt(1, 63, 1, 0, 0)));
        chk("t5_c63", 64'(c_beat), 64'(bt(1, 63, 1, 0, 0)));
        chk("t5_b2b_rdy", 64'(a_bv_in_ready), 64'd1);
        bv_in = 64'h2; bv_in_valid = 1'b1;
        tick();
        bv_in_valid = 1'b0;
        chk("t5_b2b_id1", 64'(a_beat), 64'(bt(1, 1, 1, 0, 0)));
        tick();
        chk("t5_idle", 64'(a_beat), 64'(bt(0, 0, 0, 0, 0)));

        // Reset with three pending bits discards them.
        bv_in = 64'h111; bv_in_valid = 1'b1;
        tick();
        bv_in_valid = 1'b0; id_ready = 1'b0;
        chk("t6_pre", 64'(a_beat), 64'(bt(1, 0, 0, 0, 0)));
        reset = 1'b1;
        tick();
        chk("t6_rst_beat", 64'(a_beat), 64'(bt(0, 0, 0, 0, 0)));
        chk("t6_rst_rdy", 64'(a_bv_in_ready), 64'd1);
        reset = 1'b0; id_ready = 1'b1;
        bv_in = 64'h1; bv_in_valid = 1'b1;
        tick();
        bv_in_valid = 1'b0;
        chk("t6_single", 64'(a_beat), 64'(bt(1, 0, 1, 0, 0)));
        tick();
        chk("t6_idle", 64'(a_beat), 64'(bt(0, 0, 0, 0, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
